// File: rtl/hram_rd_capture_if.sv
// ---------------------------------------------------------------------------
// hram_rd_capture_if
// Read-capture bus between the HyperRAM transaction engine / I/O buffer
// (master) and the read-data capture stage (slave).
//   start, len, abort     : burst control from the transaction engine
//   dq_word, rwds_hi      : sampled DDR beat pair and its RWDS qualifier
//   rd_data, rd_valid     : packed 32-bit read return (Avalon readdatavalid)
//   busy, done, err       : burst status
// ---------------------------------------------------------------------------
interface hram_rd_capture_if #(
    parameter int unsigned WORDS_MAX = 16
);
    localparam int unsigned LW = $clog2(WORDS_MAX) + 1;

    logic          start;
    logic [LW-1:0] len;
    logic          abort;
    logic [15:0]   dq_word;
    logic          rwds_hi;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, len, abort, dq_word, rwds_hi,
        input  rd_data, rd_valid, busy, done, err
    );

    modport slave (
        input  start, len, abort, dq_word, rwds_hi,
        output rd_data, rd_valid, busy, done, err
    );
endinterface

// File: rtl/hram_rd_capture.sv
// ---------------------------------------------------------------------------
// hram_rd_capture
// Packs valid 16-bit HyperRAM beats (RWDS high) into 32-bit read words,
// counts the requested burst length and flags completion. The first beat of
// each pair lands in rd_data[15:0].
// Ports:
//   clk   : clk0 domain clock
//   rstn  : asynchronous active-low reset
//   bus   : hram_rd_capture_if.slave (control, beat input, read return, status)
// Optional feature macro: HRAM_RD_WDOG_EN enables the beat-latency watchdog,
// which ends a stalled burst with done+err after TIMEOUT beatless cycles.
// ---------------------------------------------------------------------------
module hram_rd_capture #(
    parameter int unsigned WORDS_MAX = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    hram_rd_capture_if.slave        bus
);
    localparam int unsigned LW = $clog2(WORDS_MAX) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] wcnt, wcnt_nxt;
    logic [15:0]   lo, lo_nxt;
    logic [31:0]   rd_data_q, rd_data_nxt;
    logic          rd_valid_q, rd_valid_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;
    logic          len_ok_c;
    logic          timeout_c;

    assign len_ok_c = (bus.len != '0) && (bus.len <= LW'(WORDS_MAX));

`ifdef HRAM_RD_WDOG_EN
    // Beatless-cycle counter; held at zero while idle so start clears it.
    localparam int unsigned WDW = 8;
    logic [WDW-1:0] wdog, wdog_nxt;

    assign timeout_c = (state != IDLE) && !bus.rwds_hi && (wdog == WDW'(TIMEOUT - 1));

    always_comb begin
        wdog_nxt = wdog;
        if (state == IDLE || bus.rwds_hi) begin
            wdog_nxt = '0;
        end else begin
            wdog_nxt = wdog + WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_nxt;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^8'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && len_ok_c) state_nxt = BEAT0;
                end
                BEAT0: begin
                    if (timeout_c)        state_nxt = IDLE;
                    else if (bus.rwds_hi) state_nxt = BEAT1;
                end
                BEAT1: begin
                    if (timeout_c) begin
                        state_nxt = IDLE;
                    end else if (bus.rwds_hi) begin
                        state_nxt = (wcnt == LW'(1)) ? IDLE : BEAT0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        wcnt_nxt     = wcnt;
        lo_nxt       = lo;
        rd_data_nxt  = rd_data_q;
        rd_valid_nxt = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        if (!bus.abort) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (len_ok_c) wcnt_nxt = bus.len;
                        else          done_nxt = 1'b1;
                    end
                end
                BEAT0: begin
                    if (timeout_c) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end else if (bus.rwds_hi) begin
                        lo_nxt = bus.dq_word;
                    end
                end
                BEAT1: begin
                    if (timeout_c) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                    end else if (bus.rwds_hi) begin
                        rd_data_nxt  = {bus.dq_word, lo};
                        rd_valid_nxt = 1'b1;
                        if (wcnt == LW'(1)) done_nxt = 1'b1;
                        else                wcnt_nxt = wcnt - LW'(1);
                    end
                end
                default: ;
            endcase
        end
        // Keep busy asserted through the closing done pulse of a real burst
        busy_nxt = (state_nxt != IDLE) || (done_nxt && (state != IDLE));
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt       <= '0;
            lo         <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wcnt       <= wcnt_nxt;
            lo         <= lo_nxt;
            rd_data_q  <= rd_data_nxt;
            rd_valid_q <= rd_valid_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_hram_rd_capture.sv
// ---------------------------------------------------------------------------
// tb_hram_rd_capture
// Directed bench for hram_rd_capture. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, so each step() shows the
// registered result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_hram_rd_capture;
    logic clk;
    logic rstn;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters updated on the falling edge
    int mon_valid = 0;
    int mon_done  = 0;
    int mon_err   = 0;

    hram_rd_capture_if #(.WORDS_MAX(16)) bus_if ();

    hram_rd_capture #(
        .WORDS_MAX(16),
        .TIMEOUT  (64)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.rd_valid) mon_valid <= mon_valid + 1;
        if (bus_if.done)     mon_done  <= mon_done + 1;
        if (bus_if.err)      mon_err   <= mon_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.rwds_hi = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input logic [15:0] d);
        bus_if.rwds_hi = 1'b1;
        bus_if.dq_word = d;
        step();
        bus_if.rwds_hi = 1'b0;
        bus_if.dq_word = '0;
    endtask

    task automatic start_burst(input logic [4:0] l);
        bus_if.start = 1'b1;
        bus_if.len   = l;
        step();
        bus_if.start = 1'b0;
    endtask

    int base_v, base_d, base_e;

    task automatic mark();
        base_v = mon_valid;
        base_d = mon_done;
        base_e = mon_err;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rstn           = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.len     = '0;
        bus_if.abort   = 1'b0;
        bus_if.dq_word = '0;
        bus_if.rwds_hi = 1'b0;
        repeat (2) step();

        // Reset values
        check("rst_rd_data",  bus_if.rd_data, 32'h0);
        check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        check("rst_busy",     32'(bus_if.busy), 32'd0);
        check("rst_done",     32'(bus_if.done), 32'd0);
        check("rst_err",      32'(bus_if.err), 32'd0);
        rstn = 1'b1;
        step();

        // Single word with initial latency
        start_burst(5'd1);
        check("sw_busy_rise", 32'(bus_if.busy), 32'd1);
        idle(6);
        beat(16'hA1B2);
        check("sw_half_no_valid", 32'(bus_if.rd_valid), 32'd0);
        beat(16'hC3D4);
        check("sw_valid", 32'(bus_if.rd_valid), 32'd1);
        check("sw_data",  bus_if.rd_data, 32'hC3D4A1B2);
        check("sw_done",  32'(bus_if.done), 32'd1);
        check("sw_err",   32'(bus_if.err), 32'd0);
        check("sw_busy_in_done", 32'(bus_if.busy), 32'd1);
        idle(1);
        check("sw_valid_fall", 32'(bus_if.rd_valid), 32'd0);
        check("sw_done_fall",  32'(bus_if.done), 32'd0);
        check("sw_busy_fall",  32'(bus_if.busy), 32'd0);

        // Full 16-word burst, continuous beats
        mark();
        start_burst(5'd16);
        for (int i = 0; i < 16; i++) begin
            beat(16'(2 * i));
            check("fb_gap_valid", 32'(bus_if.rd_valid), 32'd0);
            beat(16'(2 * i + 1));
            check("fb_valid", 32'(bus_if.rd_valid), 32'd1);
            check("fb_data",  bus_if.rd_data, {16'(2 * i + 1), 16'(2 * i)});
            check("fb_done",  32'(bus_if.done), (i == 15) ? 32'd1 : 32'd0);
        end
        idle(1);
        check("fb_busy_fall", 32'(bus_if.busy), 32'd0);
        check("fb_valid_count", 32'(mon_valid - base_v), 32'd16);
        check("fb_done_count",  32'(mon_done - base_d), 32'd1);

        // Gapped RWDS
        mark();
        start_burst(5'd2);
        idle(3); beat(16'h1111);
        idle(3); beat(16'h2222);
        check("gap_w0", bus_if.rd_data, 32'h22221111);
        check("gap_w0_valid", 32'(bus_if.rd_valid), 32'd1);
        idle(3); beat(16'h3333);
        idle(3); beat(16'h4444);
        check("gap_w1", bus_if.rd_data, 32'h44443333);
        check("gap_w1_done", 32'(bus_if.done), 32'd1);
        check("gap_err", 32'(bus_if.err), 32'd0);
        idle(1);
        check("gap_valid_count", 32'(mon_valid - base_v), 32'd2);
        check("gap_err_count",   32'(mon_err - base_e), 32'd0);

`ifdef HRAM_RD_WDOG_EN
        // Watchdog: three beats then silence
        mark();
        start_burst(5'd4);
        beat(16'h0001);
        beat(16'h0002);
        check("wd_w0", bus_if.rd_data, 32'h00020001);
        beat(16'h0003);
        for (int k = 1; k <= 64; k++) begin
            idle(1);
            if (k < 64) begin
                check("wd_early_done", 32'(bus_if.done), 32'd0);
            end
        end
        check("wd_done", 32'(bus_if.done), 32'd1);
        check("wd_err",  32'(bus_if.err), 32'd1);
        check("wd_no_valid", 32'(bus_if.rd_valid), 32'd0);
        idle(1);
        check("wd_busy_fall", 32'(bus_if.busy), 32'd0);
        check("wd_valid_count", 32'(mon_valid - base_v), 32'd1);
        check("wd_err_count",   32'(mon_err - base_e), 32'd1);
`else
        // No watchdog: a stalled burst waits until aborted
        mark();
        start_burst(5'd4);
        beat(16'h0001);
        beat(16'h0002);
        beat(16'h0003);
        idle(100);
        check("nowd_busy_hold",  32'(bus_if.busy), 32'd1);
        check("nowd_done_count", 32'(mon_done - base_d), 32'd0);
        check("nowd_err_count",  32'(mon_err - base_e), 32'd0);
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        check("nowd_abort_busy", 32'(bus_if.busy), 32'd0);
        check("nowd_abort_done", 32'(bus_if.done), 32'd0);
`endif

        // Abort after first beat, then a clean single word
        mark();
        start_burst(5'd2);
        beat(16'h5555);
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        check("ab_busy", 32'(bus_if.busy), 32'd0);
        beat(16'h6666);
        beat(16'h6667);
        check("ab_ignore_idle_beats", 32'(mon_valid - base_v), 32'd0);
        check("ab_no_done", 32'(mon_done - base_d), 32'd0);
        start_burst(5'd1);
        beat(16'h7777);
        beat(16'h8888);
        check("ab_next_data", bus_if.rd_data, 32'h88887777);
        check("ab_next_done", 32'(bus_if.done), 32'd1);
        idle(1);

        // Abort coincident with the completing beat
        mark();
        start_burst(5'd1);
        beat(16'h9999);
        bus_if.abort = 1'b1;
        beat(16'h9998);
        bus_if.abort = 1'b0;
        check("abc_valid", 32'(bus_if.rd_valid), 32'd0);
        check("abc_done",  32'(bus_if.done), 32'd0);
        check("abc_busy",  32'(bus_if.busy), 32'd0);

        // Abort and start together in IDLE
        bus_if.abort = 1'b1;
        start_burst(5'd1);
        bus_if.abort = 1'b0;
        check("abs_busy", 32'(bus_if.busy), 32'd0);
        beat(16'h1234);
        beat(16'h5678);
        check("abs_valid_count", 32'(mon_valid - base_v), 32'd0);
        check("abs_done_count",  32'(mon_done - base_d), 32'd0);

        // Reset mid-burst clears outputs asynchronously
        start_burst(5'd2);
        beat(16'hBEEF);
        beat(16'hCAFE);
        check("rm_pre_valid", 32'(bus_if.rd_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rm_rd_data",  bus_if.rd_data, 32'h0);
        check("rm_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        check("rm_busy",     32'(bus_if.busy), 32'd0);
        check("rm_done",     32'(bus_if.done), 32'd0);
        rstn = 1'b1;
        step();
        mark();
        beat(16'h0F0F);
        beat(16'hF0F0);
        check("rm_idle_after", 32'(mon_valid - base_v), 32'd0);

        // Illegal lengths
        start_burst(5'd0);
        check("il0_done", 32'(bus_if.done), 32'd1);
        check("il0_busy", 32'(bus_if.busy), 32'd0);
        check("il0_err",  32'(bus_if.err), 32'd0);
        idle(1);
        check("il0_done_fall", 32'(bus_if.done), 32'd0);
        start_burst(5'd17);
        check("il17_done", 32'(bus_if.done), 32'd1);
        check("il17_busy", 32'(bus_if.busy), 32'd0);
        idle(1);

        // Second start during a live burst is ignored
        start_burst(5'd1);
        bus_if.start = 1'b1;
        bus_if.len   = 5'd3;
        beat(16'hAAAA);
        bus_if.start = 1'b0;
        beat(16'hBBBB);
        check("ss_data", bus_if.rd_data, 32'hBBBBAAAA);
        check("ss_done", 32'(bus_if.done), 32'd1);
        idle(1);
        check("ss_busy_fall", 32'(bus_if.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
